// File: rtl/fifo_12x8_pkg.sv
// ============================================================================
// Module  : fifo_12x8_pkg
// Brief   : Shared defaults and word-field positions for the FIFO and arbiter stages.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package fifo_12x8_pkg;

    localparam int C_DATA_WIDTH  = 12;
    localparam int C_DEPTH       = 8;
    localparam int C_AF_THRESH   = 6;
    localparam int C_AE_THRESH   = 2;

    // Word layout: dest[11:10] routes the word, payload[9:0] is carried through.
    localparam int C_DEST_MSB    = 11;
    localparam int C_DEST_LSB    = 10;
    localparam int C_PAYLOAD_MSB = 9;
    localparam int C_PAYLOAD_LSB = 0;

endpackage

`default_nettype wire

// File: rtl/fifo_mem.sv
// ============================================================================
// Module  : fifo_mem
// Brief   : Dual-port register array, synchronous write, asynchronous read, no reset.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module fifo_mem #(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 8
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]      rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/fifo_12x8.sv
// ============================================================================
// Module  : fifo_12x8
// Brief   : Show-ahead synchronous FIFO with occupancy flags and sticky error.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module fifo_12x8
    import fifo_12x8_pkg::*;
#(
    parameter int DATA_WIDTH = C_DATA_WIDTH,
    parameter int DEPTH      = C_DEPTH,
    parameter int AF_THRESH  = C_AF_THRESH,
    parameter int AE_THRESH  = C_AE_THRESH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DATA_WIDTH-1:0]      fifo_in,
    input  logic                       pop,
    output logic [DATA_WIDTH-1:0]      fifo_out,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       error
);

    localparam int                c_AW       = $clog2(DEPTH);
    localparam logic [c_AW:0]     c_FULL_CNT = (c_AW+1)'(DEPTH);
    localparam logic [c_AW:0]     c_AF_CNT   = (c_AW+1)'(AF_THRESH);
    localparam logic [c_AW:0]     c_AE_CNT   = (c_AW+1)'(AE_THRESH);

    logic [c_AW-1:0]       r_wr_ptr;
    logic [c_AW-1:0]       r_rd_ptr;
    logic [c_AW:0]         r_count;
    logic                  r_error;

    logic                  w_push_ok;
    logic                  w_pop_ok;
    logic                  w_fault;
    logic [DATA_WIDTH-1:0] w_rd_data;

    // A pop on a full FIFO frees the slot the push lands in, so push is still accepted.
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || pop);
    assign w_fault   = (push && full && !pop) || (pop && empty);

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (w_push_ok),
        .waddr (r_wr_ptr),
        .wdata (fifo_in),
        .raddr (r_rd_ptr),
        .rdata (w_rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_error  <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (c_AW+1)'(1);
                2'b01:   r_count <= r_count - (c_AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_fault) begin
                r_error <= 1'b1;
            end
        end
    end

    always_comb begin
        empty        = (r_count == '0);
        full         = (r_count == c_FULL_CNT);
        almost_full  = (r_count >= c_AF_CNT);
        almost_empty = (r_count <= c_AE_CNT);
        count        = r_count;
        error        = r_error;
        fifo_out     = empty ? '0 : w_rd_data;
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_12x8.sv
// ============================================================================
// Module  : tb_fifo_12x8
// Brief   : Scoreboard bench for fifo_12x8 against a queue reference model.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_12x8;

    logic        clk;
    logic        reset;
    logic        push;
    logic [11:0] fifo_in;
    logic        pop;
    logic [11:0] fifo_out;
    logic        empty;
    logic        full;
    logic        almost_full;
    logic        almost_empty;
    logic [3:0]  count;
    logic        error;

    int          n_pass = 0;
    int          n_chk  = 0;
    logic [11:0] q[$];
    logic        m_err = 1'b0;

    fifo_12x8 dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .fifo_in      (fifo_in),
        .pop          (pop),
        .fifo_out     (fifo_out),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_status(input string tag);
        int          n;
        logic [11:0] head;
        n    = q.size();
        head = (n > 0) ? q[0] : 12'h000;
        check({tag, ".count"},  32'(count),        32'(n));
        check({tag, ".empty"},  32'(empty),        32'(n == 0));
        check({tag, ".full"},   32'(full),         32'(n == 8));
        check({tag, ".af"},     32'(almost_full),  32'(n >= 6));
        check({tag, ".ae"},     32'(almost_empty), 32'(n <= 2));
        check({tag, ".error"},  32'(error),        32'(m_err));
        check({tag, ".head"},   32'(fifo_out),     32'(head));
    endtask

    // One clock of stimulus; popped data is scored against the queue head before the edge.
    task automatic step(input logic p, input logic [11:0] d, input logic r);
        logic acc_push, acc_pop;
        push    = p;
        fifo_in = d;
        pop     = r;
        #1;
        if (r && q.size() > 0) check("pop_data", 32'(fifo_out), 32'(q[0]));
        acc_pop  = r && (q.size() > 0);
        acc_push = p && ((q.size() < 8) || r);
        if ((p && q.size() == 8 && !r) || (r && q.size() == 0)) m_err = 1'b1;
        @(posedge clk);
        #1;
        if (acc_pop)  void'(q.pop_front());
        if (acc_push) q.push_back(d);
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        q.delete();
        m_err = 1'b0;
        #1;
        check_status("async_rst");
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
    endtask

    initial begin
        logic [11:0] init_vals [5];
        init_vals = '{12'h296, 12'h196, 12'h425, 12'h824, 12'hEA5};

        reset   = 1'b0;
        push    = 1'b1;
        fifo_in = 12'h3C3;
        pop     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_status("in_reset");
        push  = 1'b0;
        reset = 1'b1;
        #1;
        check_status("post_reset");

        foreach (init_vals[i]) step(1'b1, init_vals[i], 1'b0);
        check_status("five_push");

        step(1'b1, 12'h0A1, 1'b0);
        check_status("count6_af");
        step(1'b0, 12'h000, 1'b1);
        check_status("pop_af_clear");

        for (int i = 0; i < 3; i++) step(1'b1, 12'h500 + 12'(i), 1'b0);
        check_status("filled");
        step(1'b1, 12'hAA5, 1'b0);
        check_status("overflow");
        for (int i = 0; i < 8; i++) step(1'b0, 12'h000, 1'b1);
        check_status("drained");

        step(1'b1, 12'h0F0, 1'b1);
        check_status("underflow_push");

        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 12'h700 + 12'(i), 1'b0);
        step(1'b1, 12'h111, 1'b1);
        check_status("full_push_pop");
        for (int i = 0; i < 8; i++) step(1'b0, 12'h000, 1'b1);
        check_status("full_drain");

        for (int i = 0; i < 4; i++) step(1'b1, 12'h240 + 12'(i), 1'b0);
        do_reset();
        check_status("after_rst4");

        for (int i = 0; i < 10; i++) step(1'b1, 12'h900 + 12'(i), (i >= 2));
        for (int i = 0; i < 30; i++) begin
            step(1'($urandom_range(0, 1)), 12'($urandom), 1'($urandom_range(0, 1)));
            check_status("random");
        end
        while (q.size() > 0) step(1'b0, 12'h000, 1'b1);
        check_status("final");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo_12x8.md
FIFO_12X8 -- requirements
Module: fifo_12x8

Interface
REQ-001 Parameter DATA_WIDTH, default 12, shall set the word width; one word is dest[11:10] plus payload[9:0].
REQ-002 Parameter DEPTH, default 8, shall set the number of entries and shall be a power of two.
REQ-003 Parameter AF_THRESH, default 6, shall set the almost_full level.
REQ-004 Parameter AE_THRESH, default 2, shall set the almost_empty level.
REQ-005 Port clk, input, 1 bit, shall be the single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1 bit, shall be the asynchronous, active-low reset.
REQ-007 Port push, input, 1 bit, shall be the write request from the upstream producer.
REQ-008 Port fifo_in, input, DATA_WIDTH bits, shall be the write data, sampled when push=1.
REQ-009 Port pop, input, 1 bit, shall be the read request from the downstream arbiter.
REQ-010 Port fifo_out, output, DATA_WIDTH bits, shall be the head word (show-ahead).
REQ-011 Port empty, output, 1 bit, shall indicate count==0.
REQ-012 Port full, output, 1 bit, shall indicate count==DEPTH.
REQ-013 Port almost_full, output, 1 bit, shall indicate count>=AF_THRESH.
REQ-014 Port almost_empty, output, 1 bit, shall indicate count<=AE_THRESH.
REQ-015 Port count, output, log2(DEPTH)+1 bits, shall be the current occupancy.
REQ-016 Port error, output, 1 bit, shall be a sticky flag for overflow or underflow.

Function
REQ-017 Write pointer, read pointer and count shall be registers of log2(DEPTH), log2(DEPTH) and log2(DEPTH)+1 bits.
REQ-018 Pointers shall wrap from DEPTH-1 to 0 with no extra logic, through natural modulo-DEPTH overflow.
REQ-019 An accepted push shall write fifo_in at wr_ptr, increment wr_ptr, and increment count on the same edge.
REQ-020 An accepted pop shall increment rd_ptr and decrement count; the next head appears on fifo_out the following cycle.
REQ-021 fifo_out shall equal mem[rd_ptr] combinationally when empty=0, and shall be all zeros when empty=1.
REQ-022 A push written at edge N shall be visible on fifo_out after edge N when the FIFO was empty: 1-cycle write-to-read latency.
REQ-023 All flags shall be a combinational decode of the registered count; flags change only after a clock edge.
REQ-024 Push with full=1 and pop=0 shall be dropped (no write, no pointer move) and shall set error.
REQ-025 Pop with empty=1 shall be ignored and shall set error; a simultaneous push is still accepted.
REQ-026 Push and pop together with 0<count<DEPTH shall both take effect; count shall stay unchanged.
REQ-027 Push and pop together with full=1 shall both take effect, because the popped slot frees the write slot; count shall stay DEPTH and error shall not be set.
REQ-028 error, once set, shall remain 1 until reset.

Reset
REQ-029 reset=0 shall immediately and asynchronously clear wr_ptr, rd_ptr, count and error, independent of clk.
REQ-030 During and after reset the outputs shall be: empty=1, almost_empty=1, full=0, almost_full=0, count=0, fifo_out=0, error=0.
REQ-031 Memory contents shall not be reset; data in flight at reset assertion shall be discarded.
REQ-032 Push and pop shall be ignored while reset=0; the first accepted operation shall be at the first rising edge after reset deasserts.

Structure
REQ-033 DATA_WIDTH, DEPTH, AF_THRESH, AE_THRESH defaults and the dest-field bit positions shall live in a shared defines file used by the FIFO and the arbiter stages.
REQ-034 Storage shall be a sub-module fifo_mem: a dual-port register array with a synchronous write port and an asynchronous read port, and no reset.
REQ-035 Pointer, count, flag and error logic shall reside in fifo_12x8 itself.

Verification
REQ-036 Reset then 5 pushes of 12'h296, 12'h196, 12'h425, 12'h824, 12'hEA5 -> count=5; fifo_out=12'h296; almost_empty=0; almost_full=0.
REQ-037 Fill to 8 words, then push 12'hAA5 -> full=1; count=8; error=1; the 8 pops return the original order with no 12'hAA5.
REQ-038 Count=6 -> almost_full=1; 1 pop -> almost_full=0 on the next cycle; count=5.
REQ-039 Full FIFO with push 12'h111 and pop in the same cycle -> count stays 8; error=0; 12'h111 is popped last after 7 further pops.
REQ-040 Empty FIFO with pop=1 and push 12'h0F0 -> error=1; count=1; fifo_out=12'h0F0 next cycle.
REQ-041 Reset asserted mid-clock with count=4 -> empty=1, count=0, fifo_out=0 without waiting for a clk edge; 10 push/pop cycles exercise pointer wrap with correct data.
